// File: rtl/dpwm_duty_capture.sv
// Reconstructs the dithered DPWM duty word from the PWM waveform: measures high
// time per period, validates period length and sums 2^FRAC_W periods per frame.
module dpwm_duty_capture #(
  parameter int CNT_W  = 6,
  parameter int FRAC_W = 3,
  parameter int OUT_W  = CNT_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [OUT_W-1:0] duty_out,
  output logic             duty_valid,
  output logic             period_err,
  output logic             stuck_high,
  output logic             busy
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0]  PER_LAST = '1;
  localparam logic [CNT_W-1:0]  PER_ONE  = 1;
  localparam logic [CNT_W:0]    HI_ONE   = 1;
  localparam logic [CNT_W:0]    HI_FULL  = HI_ONE << CNT_W;
  localparam logic [FRAC_W-1:0] FRM_LAST = '1;
  localparam logic [FRAC_W-1:0] FRM_ONE  = 1;

  state_t state, state_nx;

  logic s1, s2, s3, rise;

  logic [CNT_W-1:0]  per_cnt, per_nx;
  logic [CNT_W:0]    hi_cnt, hi_nx;
  logic [OUT_W-1:0]  acc, acc_nx;
  logic [FRAC_W-1:0] frm_cnt, frm_nx;
  logic [OUT_W-1:0]  dout_nx;
  logic              dval_nx, perr_nx, stuck_nx;

  logic              take;
  logic [CNT_W:0]    sample;
  logic [OUT_W-1:0]  sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign busy = (state == MEAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      acc        <= '0;
      frm_cnt    <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      state      <= state_nx;
      per_cnt    <= per_nx;
      hi_cnt     <= hi_nx;
      acc        <= acc_nx;
      frm_cnt    <= frm_nx;
      duty_out   <= dout_nx;
      duty_valid <= dval_nx;
      period_err <= perr_nx;
      stuck_high <= stuck_nx;
    end
  end

  always_comb begin
    state_nx = state;
    per_nx   = per_cnt;
    hi_nx    = hi_cnt;
    acc_nx   = acc;
    frm_nx   = frm_cnt;
    dout_nx  = duty_out;
    dval_nx  = 1'b0;
    perr_nx  = 1'b0;
    stuck_nx = stuck_high;
    take     = 1'b0;
    sample   = '0;
    sum      = '0;

    if (rise) stuck_nx = 1'b0;

    if (!en) begin
      state_nx = IDLE;
      per_nx   = '0;
      hi_nx    = '0;
      acc_nx   = '0;
      frm_nx   = '0;
      stuck_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          per_nx = '0;
          hi_nx  = '0;
          acc_nx = '0;
          frm_nx = '0;
          if (rise) begin
            state_nx = MEAS;
            hi_nx    = HI_ONE;
          end
        end
        MEAS: begin
          per_nx = per_cnt + PER_ONE;
          hi_nx  = hi_cnt + {{CNT_W{1'b0}}, s2};
          if (rise) begin
            per_nx = '0;
            hi_nx  = HI_ONE;
            if (per_cnt == PER_LAST) begin
              take   = 1'b1;
              sample = hi_cnt;
            end else begin
              perr_nx = 1'b1;
              acc_nx  = '0;
              frm_nx  = '0;
            end
          end else if (per_cnt == PER_LAST) begin
            if (s2) begin
              if (hi_cnt == HI_FULL) begin
                stuck_nx = 1'b1;
                perr_nx  = 1'b1;
                state_nx = IDLE;
                per_nx   = '0;
                hi_nx    = '0;
                acc_nx   = '0;
                frm_nx   = '0;
              end else begin
                // high run continues across the window edge; keep counting it
                hi_nx = HI_ONE;
              end
            end else begin
              // no edge this window: only an all-low window is a duty-0 period,
              // a partial high (e.g. the arming pulse) is dropped
              hi_nx = '0;
              if (hi_cnt == '0) take = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    if (take) begin
      sum = acc + OUT_W'(sample);
      if (frm_cnt == FRM_LAST) begin
        dout_nx = sum;
        dval_nx = ~stuck_high;
        acc_nx  = '0;
        frm_nx  = '0;
      end else begin
        acc_nx = sum;
        frm_nx = frm_cnt + FRM_ONE;
      end
    end
  end

endmodule
